bus_demultiplexer: RTL

//  Registered 1-to-8 bus demultiplexer; the write side of the 8-channel 32-bit data bus.

---
 rtl/bus_demux_pkg.sv | 17 +
 rtl/demux_slot.sv | 67 ++++++
 rtl/bus_demultiplexer.sv | 69 ++++++
 3 files changed

// File: rtl/bus_demux_pkg.sv
// Shared constants and slot state encoding for the 1-to-8 bus demultiplexer.
// Optional delivered-word counters are enabled with macro BUS_DEMUX_COUNT_EN.
package bus_demux_pkg;

   localparam int unsigned NCH   = 8;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 16;

   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   typedef enum logic {
      StEmpty = EMPTY,
      StFull  = FULL
   } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry channel holding register with its EMPTY/FULL state.
// With macro BUS_DEMUX_COUNT_EN a 16-bit wrapping delivered-word counter is added.
module demux_slot
   import bus_demux_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] din_i,
   input  logic             qready_i,
   output logic [Width-1:0] q_o,
   output logic             qvalid_o
`ifdef BUS_DEMUX_COUNT_EN
   ,
   output logic [CNT_W-1:0] cnt_o
`endif
);

   slot_state_e      state_q;
   logic [Width-1:0] q_q;

   // Slot FSM: load fills or reloads, a consumer take without a load empties.
   // Q keeps the last word after draining; consumers qualify it with qvalid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StEmpty;
         q_q     <= '0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (load_i) begin
                  state_q <= StFull;
                  q_q     <= din_i;
               end
            end
            StFull: begin
               if (load_i) begin
                  q_q <= din_i;
               end else if (qready_i) begin
                  state_q <= StEmpty;
               end
            end
         endcase
      end
   end

   assign q_o      = q_q;
   assign qvalid_o = (state_q == StFull);

`ifdef BUS_DEMUX_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Count every delivered word; wraps naturally at the counter width.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if ((state_q == StFull) && qready_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/bus_demultiplexer.sv
// Registered 1-to-8 bus demultiplexer: one producer handshake in, eight channel handshakes out.
// Macro BUS_DEMUX_COUNT_EN adds the per-channel delivered-word count port wcount_o.
module bus_demultiplexer
   import bus_demux_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] databus_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [Width-1:0] q0_o,
   output logic [Width-1:0] q1_o,
   output logic [Width-1:0] q2_o,
   output logic [Width-1:0] q3_o,
   output logic [Width-1:0] q4_o,
   output logic [Width-1:0] q5_o,
   output logic [Width-1:0] q6_o,
   output logic [Width-1:0] q7_o,
   output logic [NCH-1:0]   qvalid_o,
   input  logic [NCH-1:0]   qready_i
`ifdef BUS_DEMUX_COUNT_EN
   ,
   output logic [NCH*CNT_W-1:0] wcount_o
`endif
);

   logic [NCH-1:0]   load;
   logic [Width-1:0] q_w [NCH];

   // Selected slot can take a word if empty or being drained this cycle.
   assign in_ready_o = ~qvalid_o[sel_i] | qready_i[sel_i];

   // Decode the accepted word to a one-hot slot load.
   always_comb begin
      load         = '0;
      load[sel_i]  = in_valid_i & in_ready_o;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_slot
      demux_slot #(
         .Width (Width)
      ) u_slot (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .load_i   (load[i]),
         .din_i    (databus_i),
         .qready_i (qready_i[i]),
         .q_o      (q_w[i]),
         .qvalid_o (qvalid_o[i])
`ifdef BUS_DEMUX_COUNT_EN
         ,
         .cnt_o    (wcount_o[CNT_W*i +: CNT_W])
`endif
      );
   end

   assign q0_o = q_w[0];
   assign q1_o = q_w[1];
   assign q2_o = q_w[2];
   assign q3_o = q_w[3];
   assign q4_o = q_w[4];
   assign q5_o = q_w[5];
   assign q6_o = q_w[6];
   assign q7_o = q_w[7];

endmodule
